// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage of a 5-stage pipeline: the program counter, the
// next-PC selector and the IF/ID pipeline register.
//
// After reset the stage spends exactly one BOOT cycle. During that cycle the
// PC holds RESET_PC, IF/ID is loaded with a bubble and all control inputs are
// ignored. The stage then runs (RUN) until the next reset.
//
// Optional feature: define IF_FETCH_PERF_CNT_EN to add the saturating
// stall_cnt / flush_cnt performance counters and their output ports.
//
// Parameters
//   RESET_PC       PC value loaded on reset
//
// Ports
//   clk            single clock, rising-edge active
//   rst            asynchronous active-high reset
//   PC_write       1 = PC may update, 0 = PC holds (hazard stall)
//   IF_ID_write    1 = IF/ID may load, 0 = IF/ID holds
//   IF_Flush       1 = IF/ID loads a bubble (overrides IF_ID_write)
//   PCSrc          next-PC select: 00 PC+4, 01 branch, 10 jump, 11 PC+4
//   branch_target  resolved branch address from ID
//   jump_target    resolved jump address from ID
//   imem_addr      instruction memory address (always equals PC)
//   imem_data      instruction word, combinational response to imem_addr
//   PC             current fetch PC
//   IF_ID_instr    registered instruction (nop for a bubble)
//   IF_ID_pc4      registered PC+4 of that instruction (0 for a bubble)
//   IF_ID_valid    1 = real instruction, 0 = bubble
//   stall_cnt      RUN cycles with PC_write=0, saturating (macro only)
//   flush_cnt      RUN cycles with IF_Flush=1, saturating (macro only)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_write,
  input  logic        IF_ID_write,
  input  logic        IF_Flush,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [31:0] NopInstr = 32'h0000_0000;

  typedef enum logic [0:0] {
    StBoot = 1'b0,
    StRun  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        run;

  assign run      = (state_q == StRun);
  // Plain 32-bit add: wraps modulo 2^32 at the top of the address space.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC selection; the 11 encoding is treated as sequential.
  always_comb begin
    next_pc = pc_plus4;
    unique case (PCSrc)
      2'b01:   next_pc = branch_target;
      2'b10:   next_pc = jump_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // FSM, PC and IF/ID next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    unique case (state_q)
      StBoot: begin
        // Control inputs are ignored; PC keeps RESET_PC and IF/ID is bubbled.
        state_d = StRun;
        pc_d    = RESET_PC;
        instr_d = NopInstr;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end
      StRun: begin
        state_d = StRun;
        // A stall beats any redirect: PC only obeys PC_write.
        if (PC_write) begin
          pc_d = next_pc;
        end
        // Flush beats a held IF/ID register.
        if (IF_Flush) begin
          instr_d = NopInstr;
          pc4_d   = 32'h0000_0000;
          valid_d = 1'b0;
        end else if (IF_ID_write) begin
          instr_d = imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= NopInstr;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters, active in RUN only.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (run && !PC_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (run && IF_Flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Without the counters the RUN decode has no consumer.
  logic unused_run;
  assign unused_run = run;
`endif

  assign PC          = pc_q;
  assign imem_addr   = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_pc4   = pc4_q;
  assign IF_ID_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. The instruction memory is modelled
// as imem_data = imem_addr ^ data_mask. A reference model tracks the
// architectural fetch state (PC, IF/ID contents, boot flag, event counts)
// and every cycle is compared against the DUT. Directed scenarios come first,
// followed by randomized control traffic with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] RstPc = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_write;
  logic        IF_ID_write;
  logic        IF_Flush;
  logic [1:0]  PCSrc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] PC;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  logic [31:0] data_mask;

  assign imem_data = imem_addr ^ data_mask;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC(RstPc)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .IF_Flush     (IF_Flush),
    .PCSrc        (PCSrc),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .PC           (PC),
    .IF_ID_instr  (IF_ID_instr),
    .IF_ID_pc4    (IF_ID_pc4),
    .IF_ID_valid  (IF_ID_valid)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  bit          m_boot;
  int          m_stall;
  int          m_flush;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RstPc;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_boot  = 1'b1;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic compare_all();
    check_eq("pc", PC, m_pc);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_id_instr", IF_ID_instr, m_instr);
    check_eq("if_id_pc4", IF_ID_pc4, m_pc4);
    check_eq("if_id_valid", {31'h0, IF_ID_valid}, {31'h0, m_valid});
`ifdef IF_FETCH_PERF_CNT_EN
    check_eq("stall_cnt", {16'h0, stall_cnt}, m_stall);
    check_eq("flush_cnt", {16'h0, flush_cnt}, m_flush);
`endif
  endtask

  // Apply one cycle of control inputs, advance the model by one clock and
  // compare everything just after the edge.
  task automatic cycle(input logic pw, input logic iw, input logic fl, input logic [1:0] src,
                       input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] seq;
    PC_write      = pw;
    IF_ID_write   = iw;
    IF_Flush      = fl;
    PCSrc         = src;
    branch_target = bt;
    jump_target   = jt;
    seq = m_pc + 32'd4;
    if (m_boot) begin
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
      m_boot  = 1'b0;
    end else begin
      if (fl) begin
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
      end else if (iw) begin
        m_instr = m_pc ^ data_mask;
        m_pc4   = seq;
        m_valid = 1'b1;
      end
      if (!pw && m_stall < 65535) m_stall++;
      if (fl && m_flush < 65535) m_flush++;
      if (pw) m_pc = (src == 2'b01) ? bt : (src == 2'b10) ? jt : seq;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Assert reset between clock edges and check it takes effect at once.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst_pc", PC, RstPc);
    check_eq("async_rst_valid", {31'h0, IF_ID_valid}, 32'h0);
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    PC_write      = 1'b0;
    IF_ID_write   = 1'b0;
    IF_Flush      = 1'b0;
    PCSrc         = 2'b00;
    branch_target = 32'h0;
    jump_target   = 32'h0;
    data_mask     = 32'h0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Boot then free run with imem_data = PC: PC 40, 40, 44, 48.
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check_eq("boot_pc", PC, 32'h40);
    check_eq("boot_valid", {31'h0, IF_ID_valid}, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check_eq("first_instr", IF_ID_instr, 32'h40);
    check_eq("first_pc4", IF_ID_pc4, 32'h44);
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check_eq("run_pc", PC, 32'h48);

    // Stall at 0x100 for two cycles.
    cycle(1'b1, 1'b1, 1'b1, 2'b01, 32'h100, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 2'b01, 32'h500, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h600);
    check_eq("stall_pc", PC, 32'h100);

    // Taken branch from 0x200 with flush.
    cycle(1'b1, 1'b1, 1'b0, 2'b01, 32'h200, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 2'b01, 32'h300, 32'h0);
    check_eq("branch_pc", PC, 32'h300);
    check_eq("branch_instr", IF_ID_instr, 32'h0);

    // Jump with flush overriding IF_ID_write=0.
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 32'h0040_0000);
    check_eq("jump_pc", PC, 32'h0040_0000);
    check_eq("jump_valid", {31'h0, IF_ID_valid}, 32'h0);

    // PC+4 wrap at the top of the address space.
    cycle(1'b1, 1'b1, 1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check_eq("wrap_pc", PC, 32'h0);
    check_eq("wrap_pc4", IF_ID_pc4, 32'h0);

    // Asynchronous reset in the middle of a stall.
    cycle(1'b0, 1'b0, 1'b0, 2'b01, 32'h800, 32'h0);
    async_reset();
    cycle(1'b1, 1'b1, 1'b1, 2'b10, 32'h900, 32'h900);
    check_eq("reboot_pc", PC, RstPc);

    // Randomized traffic with a non-trivial instruction pattern.
    data_mask = $urandom;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        async_reset();
      end else begin
        cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
              {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
